alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequencing front end for the 8-bit ALU datapath: drives the external adder and
// the 1-bit shift/rotate manipulator, and holds the registered result behind valid/ready.
module alu_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cin,
    output logic       alu_dir,
    output logic       alu_rot,
    input  logic [7:0] add_sum,
    input  logic       add_cout,
    input  logic [7:0] man_out
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpShl = 3'b010;
    localparam logic [2:0] OpShr = 3'b011;
    localparam logic [2:0] OpRol = 3'b100;
    localparam logic [2:0] OpRor = 3'b101;

    typedef enum logic [1:0] {StIdle, StExec, StShift, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] w_q, w_d;
    logic [7:0] b_q, b_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;

    logic       in_is_shift;
    logic       q_is_arith;

    assign in_is_shift = (op >= OpShl) && (op <= OpRor);
    assign q_is_arith  = (op_q == OpAdd) || (op_q == OpSub);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= 3'd0;
            w_q      <= 8'd0;
            b_q      <= 8'd0;
            cnt_q    <= 3'd0;
            result_q <= 8'd0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            w_q      <= w_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    // Datapath controls are only driven while the matching state is active.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        result    = result_q;
        carry     = carry_q;
        zero      = zero_q;
        alu_a     = w_q;
        alu_b     = 8'd0;
        alu_cin   = 1'b0;
        alu_dir   = 1'b0;
        alu_rot   = 1'b0;
        if (state_q == StExec) begin
            if (op_q == OpAdd) begin
                alu_b = b_q;
            end else if (op_q == OpSub) begin
                alu_b   = ~b_q;
                alu_cin = 1'b1;
            end
        end
        if (state_q == StShift) begin
            alu_dir = (op_q == OpShr) || (op_q == OpRor);
            alu_rot = (op_q == OpRol) || (op_q == OpRor);
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        w_d      = w_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = op;
                    w_d     = a;
                    b_d     = b;
                    cnt_d   = b[2:0];
                    state_d = (in_is_shift && (b[2:0] != 3'd0)) ? StShift : StExec;
                end
            end
            StExec: begin
                if (q_is_arith) begin
                    result_d = add_sum;
                    carry_d  = add_cout;
                end else begin
                    result_d = w_q;
                    carry_d  = 1'b0;
                end
                zero_d  = (result_d == 8'd0);
                state_d = StDone;
            end
            StShift: begin
                w_d     = man_out;
                cnt_d   = cnt_q - 3'd1;
                // Carry tracks the bit leaving W, for rotates too.
                carry_d = alu_dir ? w_q[0] : w_q[7];
                if (cnt_q == 3'd1) begin
                    result_d = man_out;
                    zero_d   = (man_out == 8'd0);
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl; the bench also plays the adder and manipulator.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic       alu_dir;
    logic       alu_rot;
    logic [7:0] add_sum;
    logic       add_cout;
    logic [7:0] man_out;

    int checks   = 0;
    int failures = 0;

    alu_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_dir   (alu_dir),
        .alu_rot   (alu_rot),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .man_out   (man_out)
    );

    always #5 clk = ~clk;

    // External combinational datapath.
    assign {add_cout, add_sum} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
    always_comb begin
        if (alu_dir) man_out = {alu_rot ? alu_a[0] : 1'b0, alu_a[7:1]};
        else         man_out = {alu_a[6:0], alu_rot ? alu_a[7] : 1'b0};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Whole-operation reference: result, carry and latency from the arithmetic rules.
    task automatic model(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                         output logic [7:0] r, output logic c, output int lat);
        int ia = int'(av);
        int ib = int'(bv);
        int n  = int'(bv[2:0]);
        int t;
        lat = 2;
        case (o)
            3'd0: begin t = ia + ib;       r = 8'(t); c = (t > 255); end
            3'd1: begin t = ia - ib + 256; r = 8'(t); c = (ia >= ib); end
            3'd2: begin r = 8'((ia << n) & 255); c = (n > 0) ? av[8-n] : 1'b0; end
            3'd3: begin r = 8'(ia >> n);         c = (n > 0) ? av[n-1] : 1'b0; end
            3'd4: begin r = 8'(((ia << n) | (ia >> (8 - n))) & 255);
                        c = (n > 0) ? av[8-n] : 1'b0; end
            3'd5: begin r = 8'(((ia >> n) | (ia << (8 - n))) & 255);
                        c = (n > 0) ? av[n-1] : 1'b0; end
            default: begin r = av; c = 1'b0; end
        endcase
        if (o >= 3'd2 && o <= 3'd5 && n > 0) lat = n + 1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] av,
                          input logic [7:0] bv);
        logic [7:0] er;
        logic       ec;
        int         elat;
        int         lat;
        model(o, av, bv, er, ec, elat);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = av; b = bv; out_ready = 1'b0;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(elat));
        chk({tag, ".result"}, 32'(result), 32'(er));
        chk({tag, ".carry"}, 32'(carry), 32'(ec));
        chk({tag, ".zero"}, 32'(zero), 32'(er == 8'd0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] er;
        logic       ec;
        int         elat;
        int         lat;
        bit         saw_valid;

        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0; out_ready = 1'b0;
        #12;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.flags", 32'({carry, zero}), 32'd0);
        chk("rst.alu", 32'({alu_a, alu_b, alu_cin, alu_dir, alu_rot}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_f0_20", 3'd0, 8'hF0, 8'h20);
        run_op("sub_eq", 3'd1, 8'h05, 8'h05);
        run_op("sub_borrow", 3'd1, 8'h03, 8'h05);
        run_op("rol3", 3'd4, 8'h81, 8'h03);
        run_op("shr1", 3'd3, 8'h81, 8'h01);
        run_op("ror1", 3'd5, 8'h01, 8'h01);
        run_op("shl7", 3'd2, 8'hFF, 8'h07);
        run_op("shl0", 3'd2, 8'h5A, 8'h08);
        run_op("pass", 3'd7, 8'h00, 8'hFF);

        // Backpressure: result held while new requests are ignored.
        model(3'd0, 8'h37, 8'hD0, er, ec, elat);
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; a = 8'h37; b = 8'hD0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp.latency", 32'(lat), 32'(elat));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0); op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
            chk("bp.result", 32'(result), 32'(er));
            chk("bp.flags", 32'({carry, zero}), 32'({ec, er == 8'd0}));
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            chk("bp.out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp.still_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.in_ready_rise", 32'(in_ready), 32'd1);
        chk("bp.result_kept", 32'(result), 32'(er));

        // Reset after two ROR steps aborts the operation.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd5; a = 8'hA5; b = 8'h07;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) saw_valid = 1'b1;
        end
        chk("abort.no_valid", 32'(saw_valid), 32'd0);
        run_op("add_after_rst", 3'd0, 8'h01, 8'h01);
        chk("add_after_rst.value", 32'(result), 32'h02);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
